exmem_stage: RTL
================

Name: exmem_stage

Overview:
- Execute stage plus EX/MEM pipeline register, directly downstream of the ID/EX register.
- Consumes the ID/EX outputs and resolves operand forwarding, ALU operation, and branch/jump redirect.
- Detects load-use hazards against the instruction currently in ID.
- Registers the result, store data, destination and memory/writeback control for the MEM stage.

Parameters:
CNT_W, 32, width of executed-instruction counter exec_count

Ports:
clk  in  1  clock, all state on rising edge
clr  in  1  synchronous active-high reset
stall  in  1  MEM not ready; hold EX/MEM register and counter
in_bubble  in  1  ID/EX holds a repeated entry; treat as NOP
rs1  in  5  source reg 1 index of EX instruction
rs2  in  5  source reg 2 index
PC_IN  in  32  PC of EX instruction
immediate  in  32  sign-extended immediate
ALU_control  in  4  ALU op
rd  in  5  destination index
rs1_val  in  32  register-file value of rs1
rs2_val  in  32  register-file value of rs2
datapath  in  11  control: [0]jump [4:1]branch [5]unsign [6]mem_read [7]ALU_WB [8]WE [9]mem_write [10]immediate_select
id_rs1  in  5  rs1 of instruction currently in ID
id_rs2  in  5  rs2 of instruction currently in ID
wb_rd  in  5  writeback destination
wb_we  in  1  writeback enable
wb_val  in  32  writeback value
alu_result_out  out  32  registered result (address for load/store)
store_data_out  out  32  registered forwarded rs2 value
rd_out  out  5  registered destination
ctrl_out  out  5  registered {mem_write,WE,ALU_WB,mem_read,unsign} = datapath[9:5]
redirect  out  1  comb: taken branch/jump in EX
redirect_pc  out  32  comb: target PC
stall_req  out  1  comb: load-use hazard, stall IF/ID and ID/EX
exec_count  out  CNT_W  executed (non-bubble) instruction count

Behaviour:
- Reset (clr=1 at edge): alu_result_out, store_data_out, rd_out, ctrl_out, exec_count all 0. clr beats stall when both are asserted.
- Forwarding, per operand (rs1, rs2):
  - If EX/MEM has ctrl_out WE=1, rd_out!=0, rd_out==rs, and mem_read=0, use alu_result_out.
  - Else if wb_we=1, wb_rd!=0, wb_rd==rs, use wb_val.
  - Else use the register-file value. x0 is never forwarded.
- Operand A = fwd rs1. Operand B = immediate if immediate_select=1, else fwd rs2.
- ALU_control: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASS_B, 11 PC_IN+immediate. 12-15 give 0.
  - Shift amount is B[4:0].
  - SLT/SLTU produce 0 or 1.
  - All arithmetic is mod 2^32.
- Jump (datapath[0]=1):
  - Result = PC_IN+4. redirect=1.
  - immediate_select=0 (JAL): redirect_pc = PC_IN+immediate.
  - immediate_select=1 (JALR): redirect_pc = (fwd rs1 + immediate) & ~1.
- Branch field, compared on fwd rs1 vs fwd rs2:
  - 0 none, 1 EQ, 2 NE, 3 LT, 4 GE. Other values: not taken.
  - unsign=1 makes LT/GE unsigned.
  - Taken: redirect=1, redirect_pc = PC_IN+immediate. Not taken: redirect=0, redirect_pc = PC_IN+4.
- redirect is forced to 0 when in_bubble=1.
- stall_req=1 when ID/EX datapath[6]=1, rd!=0, in_bubble=0, and (rd==id_rs1 or rd==id_rs2).
- Register update, one-cycle latency:
  - stall=1: hold all registers.
  - Else in_bubble=1: capture NOP (ctrl_out=0, rd_out=0, data 0).
  - Else capture the EX results.
- exec_count increments by 1 on every capture with in_bubble=0. It wraps from 2^CNT_W-1 to 0 and holds under stall.

Optional Feature:
EX_FORWARD_EN
- Defined: forwarding as above.
- Undefined: operands are always rs1_val/rs2_val, with no forwarding muxes. stall_req additionally asserts for any RAW hazard:
  - ID/EX WE=1, rd!=0, rd==id_rs1/id_rs2, in_bubble=0; or
  - EX/MEM WE=1, rd_out!=0, rd_out==id_rs1/id_rs2.

Test Plan:
- clr=1 with stall=1 and a valid instruction presented -> next cycle all outputs 0, exec_count=0.
- ADD x3,x1,x2, then SUB x4,x3,x1 with rs1_val=0 (stale), x1=5, x2=7 -> alu_result_out 12 then 7. Forwarded from EX/MEM when EX_FORWARD_EN is defined; stall_req when it is not.
- BLT PC=0x100, imm=0x20, rs1=0xFFFFFFFF, rs2=1: unsign=0 -> redirect=1, redirect_pc=0x120. unsign=1 -> redirect=0, redirect_pc=0x104.
- JALR PC=0x40, rs1=0x201, imm=4 -> redirect_pc=0x204, alu_result_out=0x44 next cycle. Same with in_bubble=1 -> redirect=0, NOP captured, exec_count unchanged.
- LW rd=5 in EX with id_rs2=5 -> stall_req=1. rd=0 -> stall_req=0.
- stall=1 for 3 cycles -> outputs and exec_count frozen. Preload exec_count to 2^CNT_W-1 and capture one instruction -> exec_count=0.

Source files
------------

// File: rtl/exmem_stage.sv
// Execute stage and EX/MEM pipeline register.
// Resolves operand forwarding, ALU operation, branch/jump redirect and
// load-use hazard detection, then registers results for the MEM stage.
// Optional feature macro: EX_FORWARD_EN (when undefined, operands come
// straight from the register file and RAW hazards are resolved by stalling).
module exmem_stage #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             stall,
   input  logic             in_bubble,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [31:0]      PC_IN,
   input  logic [31:0]      immediate,
   input  logic [3:0]       ALU_control,
   input  logic [4:0]       rd,
   input  logic [31:0]      rs1_val,
   input  logic [31:0]      rs2_val,
   input  logic [10:0]      datapath,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       wb_rd,
   input  logic             wb_we,
   input  logic [31:0]      wb_val,
   output logic [31:0]      alu_result_out,
   output logic [31:0]      store_data_out,
   output logic [4:0]       rd_out,
   output logic [4:0]       ctrl_out,
   output logic             redirect,
   output logic [31:0]      redirect_pc,
   output logic             stall_req,
   output logic [CNT_W-1:0] exec_count
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned RW   = 5;
   localparam int unsigned CW   = 5;

   // datapath control bit positions
   localparam int unsigned DP_JUMP   = 0;
   localparam int unsigned DP_UNSIGN = 5;
   localparam int unsigned DP_MEMRD  = 6;
   localparam int unsigned DP_WE     = 8;
   localparam int unsigned DP_IMMSEL = 10;

   // ctrl_out bit positions ({mem_write,WE,ALU_WB,mem_read,unsign})
   localparam int unsigned CT_MEMRD = 1;
   localparam int unsigned CT_WE    = 3;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;
   localparam logic [3:0] ALU_PASS = 4'd10;
   localparam logic [3:0] ALU_AUIP = 4'd11;

   localparam logic [3:0] BR_EQ = 4'd1;
   localparam logic [3:0] BR_NE = 4'd2;
   localparam logic [3:0] BR_LT = 4'd3;
   localparam logic [3:0] BR_GE = 4'd4;

   logic [XLEN-1:0]  alu_result_q, alu_result_d;
   logic [XLEN-1:0]  store_data_q, store_data_d;
   logic [RW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    ctrl_q, ctrl_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [XLEN-1:0]  fwd_rs1, fwd_rs2, op_b, alu_res, ex_result;
   logic [XLEN-1:0]  pc_plus4, pc_imm, target;
   logic [4:0]       shamt;
   logic             br_taken, redir_raw, lt_cmp, load_use;

`ifdef EX_FORWARD_EN
   logic exmem_fwd_ok;
   assign exmem_fwd_ok = ctrl_q[CT_WE] && (rd_q != '0) && !ctrl_q[CT_MEMRD];

   // Forwarding mux: EX/MEM result first, then writeback, else register file
   always_comb begin
      fwd_rs1 = rs1_val;
      if (exmem_fwd_ok && (rd_q == rs1)) begin
         fwd_rs1 = alu_result_q;
      end else if (wb_we && (wb_rd != '0) && (wb_rd == rs1)) begin
         fwd_rs1 = wb_val;
      end
      fwd_rs2 = rs2_val;
      if (exmem_fwd_ok && (rd_q == rs2)) begin
         fwd_rs2 = alu_result_q;
      end else if (wb_we && (wb_rd != '0) && (wb_rd == rs2)) begin
         fwd_rs2 = wb_val;
      end
   end
`else
   logic unused_wb;
   assign unused_wb = ^{wb_rd, wb_we, wb_val};
   assign fwd_rs1   = rs1_val;
   assign fwd_rs2   = rs2_val;
`endif

   assign op_b     = datapath[DP_IMMSEL] ? immediate : fwd_rs2;
   assign shamt    = op_b[4:0];
   assign pc_plus4 = PC_IN + 32'd4;
   assign pc_imm   = PC_IN + immediate;

   // ALU operation select
   always_comb begin
      alu_res = '0;
      unique case (ALU_control)
         ALU_ADD:  alu_res = fwd_rs1 + op_b;
         ALU_SUB:  alu_res = fwd_rs1 - op_b;
         ALU_AND:  alu_res = fwd_rs1 & op_b;
         ALU_OR:   alu_res = fwd_rs1 | op_b;
         ALU_XOR:  alu_res = fwd_rs1 ^ op_b;
         ALU_SLL:  alu_res = fwd_rs1 << shamt;
         ALU_SRL:  alu_res = fwd_rs1 >> shamt;
         ALU_SRA:  alu_res = XLEN'($signed(fwd_rs1) >>> shamt);
         ALU_SLT:  alu_res = XLEN'($signed(fwd_rs1) < $signed(op_b));
         ALU_SLTU: alu_res = XLEN'(fwd_rs1 < op_b);
         ALU_PASS: alu_res = op_b;
         ALU_AUIP: alu_res = pc_imm;
         default:  alu_res = '0;
      endcase
   end

   // Branch condition on forwarded rs1 vs rs2
   always_comb begin
      br_taken = 1'b0;
      lt_cmp   = datapath[DP_UNSIGN] ? (fwd_rs1 < fwd_rs2)
                                     : ($signed(fwd_rs1) < $signed(fwd_rs2));
      unique case (datapath[4:1])
         BR_EQ:   br_taken = (fwd_rs1 == fwd_rs2);
         BR_NE:   br_taken = (fwd_rs1 != fwd_rs2);
         BR_LT:   br_taken = lt_cmp;
         BR_GE:   br_taken = !lt_cmp;
         default: br_taken = 1'b0;
      endcase
   end

   // Redirect target and EX result; jumps take priority over branches
   always_comb begin
      redir_raw = 1'b0;
      target    = pc_plus4;
      ex_result = alu_res;
      if (datapath[DP_JUMP]) begin
         redir_raw = 1'b1;
         ex_result = pc_plus4;
         target    = datapath[DP_IMMSEL] ? ((fwd_rs1 + immediate) & ~32'd1) : pc_imm;
      end else if (br_taken) begin
         redir_raw = 1'b1;
         target    = pc_imm;
      end
   end

   assign redirect    = redir_raw && !in_bubble;
   assign redirect_pc = target;

   assign load_use = datapath[DP_MEMRD] && (rd != '0) && !in_bubble &&
                     ((rd == id_rs1) || (rd == id_rs2));

`ifdef EX_FORWARD_EN
   assign stall_req = load_use;
`else
   // Without forwarding, any in-flight writer of an ID source must drain first
   logic idex_raw, exmem_raw;
   assign idex_raw  = datapath[DP_WE] && (rd != '0) && !in_bubble &&
                      ((rd == id_rs1) || (rd == id_rs2));
   assign exmem_raw = ctrl_q[CT_WE] && (rd_q != '0) &&
                      ((rd_q == id_rs1) || (rd_q == id_rs2));
   assign stall_req = load_use || idex_raw || exmem_raw;
`endif

   // Next-state for EX/MEM register and executed-instruction counter
   always_comb begin
      alu_result_d = alu_result_q;
      store_data_d = store_data_q;
      rd_d         = rd_q;
      ctrl_d       = ctrl_q;
      count_d      = count_q;
      if (!stall) begin
         if (in_bubble) begin
            alu_result_d = '0;
            store_data_d = '0;
            rd_d         = '0;
            ctrl_d       = '0;
         end else begin
            alu_result_d = ex_result;
            store_data_d = fwd_rs2;
            rd_d         = rd;
            ctrl_d       = datapath[9:5];
            count_d      = count_q + CNT_W'(1);
         end
      end
   end

   // State register with synchronous clear
   always_ff @(posedge clk) begin
      if (clr) begin
         alu_result_q <= '0;
         store_data_q <= '0;
         rd_q         <= '0;
         ctrl_q       <= '0;
         count_q      <= '0;
      end else begin
         alu_result_q <= alu_result_d;
         store_data_q <= store_data_d;
         rd_q         <= rd_d;
         ctrl_q       <= ctrl_d;
         count_q      <= count_d;
      end
   end

   assign alu_result_out = alu_result_q;
   assign store_data_out = store_data_q;
   assign rd_out         = rd_q;
   assign ctrl_out       = ctrl_q;
   assign exec_count     = count_q;

endmodule
